sv_inside_matcher: RTL and testbench

//   Pipelined, programmable set-membership engine: evaluates "q inside {e0..eN-1}"

---
 rtl/sv_inside_pkg.sv | 38 +++
 rtl/sv_inside_cmp.sv | 34 +++
 rtl/sv_inside_matcher.sv | 124 ++++++++++++
 tb/tb_sv_inside_matcher.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sv_inside_pkg.sv
// Shared types and compare helper for the set-membership engine.
// SV_INSIDE_WILDCARD_EN adds a per-entry wildcard mask to entry_t.
package sv_inside_pkg;

    localparam int MAXW = 64;

    typedef enum logic {
        MODE_RANGE = 1'b0,
        MODE_POINT = 1'b1
    } mode_e;

    typedef struct packed {
        logic            en;
        mode_e           mode;
        logic            sgn;
        logic [MAXW-1:0] lo;
        logic [MAXW-1:0] hi;
`ifdef SV_INSIDE_WILDCARD_EN
        logic [MAXW-1:0] mask;
`endif
    } entry_t;

    // Operands are zero-extended w-bit values; flipping bit w-1 maps a signed
    // compare onto an unsigned one.
    function automatic logic inside_cmp_ge(input logic [MAXW-1:0] a,
                                           input logic [MAXW-1:0] b,
                                           input logic            sgn,
                                           input int unsigned     w);
        logic [MAXW-1:0] top;
        logic [MAXW-1:0] ak;
        logic [MAXW-1:0] bk;
        top = {{(MAXW-1){1'b0}}, 1'b1} << (w - 1);
        ak  = a ^ ({MAXW{sgn}} & top);
        bk  = b ^ ({MAXW{sgn}} & top);
        return ak >= bk;
    endfunction

endpackage

// File: rtl/sv_inside_cmp.sv
// Single table entry matcher: combinational RANGE/POINT test of one query
// in the entry's own signedness context (SV_INSIDE_WILDCARD_EN: masked POINT).
module sv_inside_cmp
    import sv_inside_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  entry_t           entry,
    input  logic [WIDTH-1:0] q,
    input  logic             q_signed,
    output logic             match
);

    logic [MAXW-1:0] qx;
    logic            sgn;
    logic            range_hit;
    logic            point_hit;

    assign qx  = MAXW'(q);
    assign sgn = q_signed & entry.sgn;

    // lo > hi makes the two halves mutually exclusive, so it never matches.
    assign range_hit = inside_cmp_ge(qx, entry.lo, sgn, WIDTH) &
                       inside_cmp_ge(entry.hi, qx, sgn, WIDTH);

`ifdef SV_INSIDE_WILDCARD_EN
    assign point_hit = ((qx ^ entry.lo) & ~entry.mask) == '0;
`else
    assign point_hit = (qx == entry.lo);
`endif

    assign match = entry.en & ((entry.mode == MODE_POINT) ? point_hit : range_hit);

endmodule

// File: rtl/sv_inside_matcher.sv
// Pipelined "q inside {table}" engine: table, S1/S2 pipeline, priority encoder,
// saturating hit counter. Optional macro: SV_INSIDE_WILDCARD_EN.
module sv_inside_matcher
    import sv_inside_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NRANGES = 4,
    parameter  int CNTW    = 16,
    localparam int IW      = (NRANGES > 1) ? $clog2(NRANGES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IW-1:0]      cfg_idx,
    input  logic               cfg_en,
    input  logic               cfg_mode,
    input  logic               cfg_signed,
    input  logic [WIDTH-1:0]   cfg_lo,
    input  logic [WIDTH-1:0]   cfg_hi,
    input  logic [WIDTH-1:0]   cfg_mask,
    input  logic               cfg_clr,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [WIDTH-1:0]   q_data,
    input  logic               q_signed,
    output logic               r_valid,
    input  logic               r_ready,
    output logic               r_hit,
    output logic [NRANGES-1:0] r_hitmask,
    output logic [IW-1:0]      r_first,
    output logic [CNTW-1:0]    hit_count
);

    entry_t               tbl [NRANGES];
    entry_t               wr_entry;
    logic [2:1]           vld_pipe;
    logic [WIDTH-1:0]     s1_data;
    logic                 s1_sgn;
    logic [NRANGES-1:0]   match;
    logic [IW-1:0]        first;
    logic                 advance;

    always_comb begin
        wr_entry      = '0;
        wr_entry.en   = cfg_en;
        wr_entry.mode = mode_e'(cfg_mode);
        wr_entry.sgn  = cfg_signed;
        wr_entry.lo   = MAXW'(cfg_lo);
        wr_entry.hi   = MAXW'(cfg_hi);
`ifdef SV_INSIDE_WILDCARD_EN
        wr_entry.mask = MAXW'(cfg_mask);
`endif
    end

`ifndef SV_INSIDE_WILDCARD_EN
    logic unused_mask;
    assign unused_mask = ^cfg_mask;
`endif

    // Only the enables need a reset value; the rest is qualified by en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NRANGES; i++) tbl[i].en <= 1'b0;
        end else begin
            for (int i = 0; i < NRANGES; i++) begin
                if (cfg_clr)                          tbl[i].en <= 1'b0;
                else if (cfg_we && int'(cfg_idx) == i) tbl[i]    <= wr_entry;
            end
        end
    end

    assign advance = ~vld_pipe[2] | r_ready;
    assign q_ready = ~vld_pipe[1] | advance;
    assign r_valid = vld_pipe[2];

    for (genvar g = 0; g < NRANGES; g++) begin : g_cmp
        sv_inside_cmp #(.WIDTH(WIDTH)) u_cmp (
            .entry    (tbl[g]),
            .q        (s1_data),
            .q_signed (s1_sgn),
            .match    (match[g])
        );
    end

    always_comb begin
        first = '0;
        for (int i = NRANGES - 1; i >= 0; i--) begin
            if (match[i]) first = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            s1_data   <= '0;
            s1_sgn    <= 1'b0;
            r_hit     <= 1'b0;
            r_hitmask <= '0;
            r_first   <= '0;
        end else begin
            if (q_ready) begin
                vld_pipe[1] <= q_valid;
                if (q_valid) begin
                    s1_data <= q_data;
                    s1_sgn  <= q_signed;
                end
            end
            if (advance) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    r_hit     <= |match;
                    r_hitmask <= match;
                    r_first   <= first;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                               hit_count <= '0;
        else if (r_valid && r_ready && r_hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
    end

endmodule

// File: tb/tb_sv_inside_matcher.sv
// Directed bench for sv_inside_matcher (WIDTH=4, NRANGES=4): vector table plus
// stall, reset and (with SV_INSIDE_WILDCARD_EN) wildcard sequences.
module tb_sv_inside_matcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we, cfg_en, cfg_mode, cfg_signed, cfg_clr;
    logic [1:0] cfg_idx;
    logic [3:0] cfg_lo, cfg_hi, cfg_mask;
    logic       q_valid, q_ready, q_signed;
    logic [3:0] q_data;
    logic       r_valid, r_ready, r_hit;
    logic [3:0] r_hitmask;
    logic [1:0] r_first;
    logic [15:0] hit_count;

    int errors = 0;
    int checks = 0;

    sv_inside_matcher #(.WIDTH(4), .NRANGES(4), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_signed(cfg_signed), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_mask(cfg_mask),
        .cfg_clr(cfg_clr),
        .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data), .q_signed(q_signed),
        .r_valid(r_valid), .r_ready(r_ready), .r_hit(r_hit), .r_hitmask(r_hitmask),
        .r_first(r_first), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         clr, we;
        logic [1:0] idx;
        bit         en, mode, sgn;
        logic [3:0] lo, hi, qd;
        bit         qs;
        bit         ehit;
        logic [3:0] emask;
        logic [1:0] efirst;
    } vec_t;

    vec_t       vt [15];
    logic [3:0] sv [8];
    logic [3:0] em [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_wr(input bit clr, input bit we, input logic [1:0] idx, input bit en,
                          input bit mode, input bit sgn, input logic [3:0] lo,
                          input logic [3:0] hi, input logic [3:0] mask);
        cfg_clr = clr; cfg_we = we; cfg_idx = idx; cfg_en = en; cfg_mode = mode;
        cfg_signed = sgn; cfg_lo = lo; cfg_hi = hi; cfg_mask = mask;
        tick();
        cfg_we = 1'b0; cfg_clr = 1'b0;
    endtask

    // Issues one query into an empty pipeline; lat counts edges until r_valid.
    task automatic do_query(input logic [3:0] d, input bit s, output int lat);
        q_valid = 1'b1; q_data = d; q_signed = s;
        tick();
        q_valid = 1'b0;
        lat = 1;
        while (!r_valid && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, sent, rcv;
        bit pstall, phit;
        logic [3:0] pmask;
        logic [1:0] pfirst;

        //            clr we idx en mode sgn lo    hi    qd    qs hit mask     first
        vt[0]  = '{0, 1, 2'd0, 1, 1, 1, 4'hC, 4'h0, 4'hC, 1, 1, 4'b0001, 2'd0};
        vt[1]  = '{0, 1, 2'd0, 1, 0, 1, 4'hC, 4'h0, 4'hC, 1, 1, 4'b0001, 2'd0};
        vt[2]  = '{0, 0, 2'd0, 0, 0, 0, 4'h0, 4'h0, 4'hC, 0, 0, 4'b0000, 2'd0};
        vt[3]  = '{0, 1, 2'd0, 0, 0, 1, 4'hC, 4'h0, 4'hC, 1, 0, 4'b0000, 2'd0};
        vt[4]  = '{0, 1, 2'd1, 1, 0, 0, 4'h0, 4'h1, 4'h1, 0, 1, 4'b0010, 2'd1};
        vt[5]  = '{0, 1, 2'd2, 1, 0, 1, 4'hC, 4'h0, 4'hC, 1, 1, 4'b0100, 2'd2};
        vt[6]  = '{0, 0, 2'd0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 1, 4'b0110, 2'd1};
        vt[7]  = '{0, 1, 2'd3, 1, 0, 0, 4'h5, 4'h2, 4'h3, 0, 0, 4'b0000, 2'd0};
        vt[8]  = '{0, 0, 2'd0, 0, 0, 0, 4'h0, 4'h0, 4'h5, 0, 0, 4'b0000, 2'd0};
        vt[9]  = '{0, 1, 2'd3, 1, 1, 0, 4'hF, 4'h0, 4'hF, 1, 1, 4'b1100, 2'd2};
        vt[10] = '{0, 0, 2'd0, 0, 0, 0, 4'h0, 4'h0, 4'h7, 1, 0, 4'b0000, 2'd0};
        vt[11] = '{0, 1, 2'd0, 1, 0, 1, 4'h8, 4'h7, 4'h8, 1, 1, 4'b0001, 2'd0};
        vt[12] = '{0, 0, 2'd0, 0, 0, 0, 4'h0, 4'h0, 4'h8, 0, 0, 4'b0000, 2'd0};
        vt[13] = '{1, 1, 2'd1, 1, 1, 0, 4'h3, 4'h0, 4'h3, 0, 0, 4'b0000, 2'd0};
        vt[14] = '{0, 0, 2'd0, 0, 0, 0, 4'h0, 4'h0, 4'hF, 1, 0, 4'b0000, 2'd0};

        sv = '{4'h3, 4'h9, 4'h4, 4'hC, 4'h0, 4'hF, 4'h7, 4'h8};
        em = '{4'b0001, 4'b0010, 4'b1001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0000};

        rst_n = 1'b0;
        cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_mode = 0; cfg_signed = 0;
        cfg_lo = 0; cfg_hi = 0; cfg_mask = 0; cfg_clr = 0;
        q_valid = 0; q_data = 0; q_signed = 0; r_ready = 1'b1;
        repeat (2) tick();
        chk("reset q_ready", 32'(q_ready), 32'd1);
        chk("reset r_valid", 32'(r_valid), 32'd0);
        chk("reset r_hit", 32'(r_hit), 32'd0);
        chk("reset r_hitmask", 32'(r_hitmask), 32'd0);
        chk("reset r_first", 32'(r_first), 32'd0);
        chk("reset hit_count", 32'(hit_count), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            if (vt[i].we || vt[i].clr)
                cfg_wr(vt[i].clr, vt[i].we, vt[i].idx, vt[i].en, vt[i].mode, vt[i].sgn,
                       vt[i].lo, vt[i].hi, 4'h0);
            do_query(vt[i].qd, vt[i].qs, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d r_hit", i), 32'(r_hit), 32'(vt[i].ehit));
            chk($sformatf("vec%0d r_hitmask", i), 32'(r_hitmask), 32'(vt[i].emask));
            chk($sformatf("vec%0d r_first", i), 32'(r_first), 32'(vt[i].efirst));
        end
        tick();
        chk("table hit_count", 32'(hit_count), 32'd7);

        // Back-to-back stream with r_ready low for cycles 3..5.
        cfg_wr(1, 0, 2'd0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
        cfg_wr(0, 1, 2'd0, 1, 0, 0, 4'h0, 4'h7, 4'h0);
        cfg_wr(0, 1, 2'd1, 1, 1, 0, 4'h9, 4'h0, 4'h0);
        cfg_wr(0, 1, 2'd2, 1, 0, 0, 4'hC, 4'hF, 4'h0);
        cfg_wr(0, 1, 2'd3, 1, 1, 0, 4'h4, 4'h0, 4'h0);
        sent = 0; rcv = 0; pstall = 0; phit = 0; pmask = 0; pfirst = 0;
        q_signed = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            r_ready = !(cyc >= 3 && cyc <= 5);
            q_valid = (sent < 8);
            if (sent < 8) q_data = sv[sent];
            #1;
            if (pstall) begin
                chk($sformatf("stall%0d r_valid", cyc), 32'(r_valid), 32'd1);
                chk($sformatf("stall%0d r_hitmask", cyc), 32'(r_hitmask), 32'(pmask));
                chk($sformatf("stall%0d r_hit", cyc), 32'(r_hit), 32'(phit));
                chk($sformatf("stall%0d r_first", cyc), 32'(r_first), 32'(pfirst));
            end
            if (r_valid && r_ready) begin
                chk($sformatf("stream%0d r_hitmask", rcv), 32'(r_hitmask), 32'(em[rcv]));
                chk($sformatf("stream%0d r_hit", rcv), 32'(r_hit), 32'(em[rcv] != 4'h0));
                rcv++;
            end
            pstall = r_valid && !r_ready;
            phit = r_hit; pmask = r_hitmask; pfirst = r_first;
            if (q_valid && q_ready) sent++;
            tick();
        end
        q_valid = 1'b0;
        r_ready = 1'b1;
        chk("stream received", 32'(rcv), 32'd8);
        repeat (3) tick();
        chk("stream drained r_valid", 32'(r_valid), 32'd0);
        chk("stream hit_count", 32'(hit_count), 32'd14);

        // Reset while the pipeline is full and stalled.
        r_ready = 1'b0;
        q_valid = 1'b1; q_data = 4'h3;
        tick();
        tick();
        q_valid = 1'b0;
        chk("pre-reset r_valid", 32'(r_valid), 32'd1);
        chk("full stall q_ready", 32'(q_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async reset r_valid", 32'(r_valid), 32'd0);
        chk("async reset hit_count", 32'(hit_count), 32'd0);
        chk("async reset q_ready", 32'(q_ready), 32'd1);
        chk("async reset r_hitmask", 32'(r_hitmask), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        r_ready = 1'b1;
        tick();
        do_query(4'h3, 1'b0, lat);
        chk("post-reset latency", 32'(lat), 32'd2);
        chk("post-reset r_hit", 32'(r_hit), 32'd0);
        chk("post-reset r_hitmask", 32'(r_hitmask), 32'd0);

`ifdef SV_INSIDE_WILDCARD_EN
        cfg_wr(0, 1, 2'd0, 1, 1, 0, 4'h8, 4'h0, 4'h3);
        do_query(4'hA, 1'b0, lat);
        chk("wild q=1010 r_hit", 32'(r_hit), 32'd1);
        chk("wild q=1010 r_hitmask", 32'(r_hitmask), 32'b0001);
        do_query(4'hC, 1'b0, lat);
        chk("wild q=1100 r_hit", 32'(r_hit), 32'd0);
        chk("wild q=1100 r_hitmask", 32'(r_hitmask), 32'b0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
